axi4_burst_slave: RTL and testbench

- Second-generation AXI4 memory-mapped slave backed by on-chip RAM.
- Adds FIXED/INCR/WRAP bursts, WSTRB byte strobes, ID echo and parametrised data width.
- Burst-level error checking at address acceptance.
- Independent read and write FSMs drive a simple dual-port byte-enable RAM, so reads and writes never contend.

---
 rtl/axi4_pkg.sv | 36 +++
 rtl/axi4_be_memory.sv | 23 ++
 rtl/axi4_burst_slave.sv | 138 +++++++++++++
 tb/tb_axi4_burst_slave.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/axi4_pkg.sv
// axi4_pkg: burst/response constants, FSM state types and burst address/error helpers.
package axi4_pkg;
  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  typedef logic [31:0] addr_t;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} r_state_t;
  // Computed wide; callers truncate to their address width, which keeps modular semantics.
  function automatic addr_t axi_next_addr(input addr_t addr, input logic [2:0] size,
                                          input logic [7:0] len, input logic [1:0] burst);
    addr_t bytes, total;
    bytes = addr_t'(1) << size;
    total = (addr_t'(len) + addr_t'(1)) << size;
    return burst == BURST_FIXED ? addr :
           burst == BURST_WRAP  ? (addr & ~(total - 1)) | ((addr + bytes) & (total - 1)) :
                                  (addr & ~(bytes - 1)) + bytes;
  endfunction
  function automatic logic axi_burst_err(input addr_t addr, input logic [2:0] size,
                                         input logic [7:0] len, input logic [1:0] burst,
                                         input int lb, input int depth);
    addr_t bytes, total, last;
    bytes = addr_t'(1) << size;
    total = (addr_t'(len) + addr_t'(1)) << size;
    last  = burst == BURST_FIXED ? addr :
            burst == BURST_WRAP  ? (addr & ~(total - 1)) + total - bytes :
                                   (addr & ~(bytes - 1)) + total - bytes;
    return (addr_t'(size) > addr_t'(lb)) || (burst == 2'b11) ||
           (burst == BURST_WRAP && !(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15)) ||
           (burst == BURST_WRAP && (addr & (bytes - 1)) != 0) ||
           (burst == BURST_INCR && (addr & 32'hFFF) + total > 32'h1000) ||
           ((addr >> lb) >= addr_t'(depth)) || ((last >> lb) >= addr_t'(depth));
  endfunction
endpackage

// File: rtl/axi4_be_memory.sv
// axi4_be_memory: simple dual-port RAM, byte-enable write port, 1-cycle synchronous read port.
module axi4_be_memory #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 1024,
  parameter int AW         = $clog2(DEPTH)
) (
  input  logic                    i_clk,
  input  logic                    i_we,
  input  logic [AW-1:0]           i_waddr,
  input  logic [DATA_WIDTH-1:0]   i_wdata,
  input  logic [DATA_WIDTH/8-1:0] i_wstrb,
  input  logic                    i_re,
  input  logic [AW-1:0]           i_raddr,
  output logic [DATA_WIDTH-1:0]   o_rdata
);
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  // Read and write share one block so a same-word collision returns the old data.
  always_ff @(posedge i_clk) begin
    for (int b = 0; b < DATA_WIDTH/8; b++)
      if (i_we && i_wstrb[b]) r_mem[i_waddr][b*8 +: 8] <= i_wdata[b*8 +: 8];
    if (i_re) o_rdata <= r_mem[i_raddr];
  end
endmodule

// File: rtl/axi4_burst_slave.sv
// axi4_burst_slave: AXI4 burst slave on byte-enable RAM with independent read and write FSMs.
module axi4_burst_slave
  import axi4_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 16,
  parameter int ID_WIDTH     = 4,
  parameter int MEMORY_DEPTH = 1024
) (
  input  logic                    ACLK,
  input  logic                    ARESETn,
  input  logic [ID_WIDTH-1:0]     AWID,
  input  logic [ADDR_WIDTH-1:0]   AWADDR,
  input  logic [7:0]              AWLEN,
  input  logic [2:0]              AWSIZE,
  input  logic [1:0]              AWBURST,
  input  logic                    AWVALID,
  output logic                    AWREADY,
  input  logic [DATA_WIDTH-1:0]   WDATA,
  input  logic [DATA_WIDTH/8-1:0] WSTRB,
  input  logic                    WLAST,
  input  logic                    WVALID,
  output logic                    WREADY,
  output logic [ID_WIDTH-1:0]     BID,
  output logic [1:0]              BRESP,
  output logic                    BVALID,
  input  logic                    BREADY,
  input  logic [ID_WIDTH-1:0]     ARID,
  input  logic [ADDR_WIDTH-1:0]   ARADDR,
  input  logic [7:0]              ARLEN,
  input  logic [2:0]              ARSIZE,
  input  logic [1:0]              ARBURST,
  input  logic                    ARVALID,
  output logic                    ARREADY,
  output logic [ID_WIDTH-1:0]     RID,
  output logic [DATA_WIDTH-1:0]   RDATA,
  output logic [1:0]              RRESP,
  output logic                    RLAST,
  output logic                    RVALID,
  input  logic                    RREADY
);
  localparam int NB = DATA_WIDTH/8;
  localparam int LB = $clog2(NB);
  localparam int MW = $clog2(MEMORY_DEPTH);
  w_state_t r_wstate, w_wstate_nxt;
  r_state_t r_rstate, w_rstate_nxt;
  logic [ID_WIDTH-1:0]   r_wid, r_rid;
  logic [ADDR_WIDTH-1:0] r_waddr, r_raddr;
  logic [7:0]            r_wlen, r_wcnt, r_rlen, r_rcnt;
  logic [2:0]            r_wsize, r_rsize;
  logic [1:0]            r_wburst, r_rburst, r_bresp;
  logic                  r_werr, r_wlast_err, r_rerr;
  logic                  w_aw_hs, w_w_hs, w_w_final, w_ar_hs, w_r_hs, w_rlast, w_we, w_re;
  logic [DATA_WIDTH-1:0] w_rdata;
  assign w_aw_hs   = AWVALID & AWREADY;
  assign w_w_hs    = WVALID & WREADY;
  assign w_w_final = w_w_hs & (r_wcnt == 8'd0);
  assign w_ar_hs   = ARVALID & ARREADY;
  assign w_r_hs    = RVALID & RREADY;
  assign w_rlast   = r_rcnt == 8'd0;
  assign w_we      = w_w_hs & ~r_werr;
  assign w_re      = (r_rstate == R_FETCH) & ~r_rerr;
  axi4_be_memory #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(MEMORY_DEPTH), .AW(MW)) u_mem (
    .i_clk(ACLK), .i_we(w_we), .i_waddr(MW'(r_waddr >> LB)), .i_wdata(WDATA), .i_wstrb(WSTRB),
    .i_re(w_re), .i_raddr(MW'(r_raddr >> LB)), .o_rdata(w_rdata)
  );
  always_ff @(posedge ACLK or negedge ARESETn)
    if (!ARESETn) begin
      r_wstate <= W_IDLE;
      r_rstate <= R_IDLE;
    end else begin
      r_wstate <= w_wstate_nxt;
      r_rstate <= w_rstate_nxt;
    end
  always_comb begin
    AWREADY      = r_wstate == W_IDLE;
    WREADY       = r_wstate == W_DATA;
    BVALID       = r_wstate == W_RESP;
    BID          = r_wid;
    BRESP        = r_bresp;
    w_wstate_nxt = r_wstate == W_IDLE ? (AWVALID ? W_DATA : W_IDLE) :
                   r_wstate == W_DATA ? (w_w_final ? W_RESP : W_DATA) :
                                        (BREADY ? W_IDLE : W_RESP);
  end
  // The write burst ends on the counter, not on WLAST; a WLAST disagreement only taints BRESP.
  always_ff @(posedge ACLK or negedge ARESETn)
    if (!ARESETn) begin
      r_wid <= '0; r_waddr <= '0; r_wlen <= '0; r_wcnt <= '0; r_wsize <= '0;
      r_wburst <= '0; r_werr <= 1'b0; r_wlast_err <= 1'b0; r_bresp <= RESP_OKAY;
    end else begin
      if (w_aw_hs) begin
        r_wid       <= AWID;
        r_waddr     <= AWADDR;
        r_wlen      <= AWLEN;
        r_wcnt      <= AWLEN;
        r_wsize     <= AWSIZE;
        r_wburst    <= AWBURST;
        r_werr      <= axi_burst_err(addr_t'(AWADDR), AWSIZE, AWLEN, AWBURST, LB, MEMORY_DEPTH);
        r_wlast_err <= 1'b0;
      end
      if (w_w_hs) begin
        r_waddr     <= ADDR_WIDTH'(axi_next_addr(addr_t'(r_waddr), r_wsize, r_wlen, r_wburst));
        r_wcnt      <= r_wcnt - 8'd1;
        r_wlast_err <= r_wlast_err | (WLAST != (r_wcnt == 8'd0));
      end
      if (w_w_final) r_bresp <= (r_werr | r_wlast_err | ~WLAST) ? RESP_SLVERR : RESP_OKAY;
    end
  always_comb begin
    ARREADY      = r_rstate == R_IDLE;
    RVALID       = r_rstate == R_DATA;
    RLAST        = RVALID & w_rlast;
    RID          = r_rid;
    RRESP        = (RVALID & r_rerr) ? RESP_SLVERR : RESP_OKAY;
    RDATA        = (RVALID & ~r_rerr) ? w_rdata : '0;
    w_rstate_nxt = r_rstate == R_IDLE  ? (ARVALID ? R_FETCH : R_IDLE) :
                   r_rstate == R_FETCH ? R_DATA :
                   w_r_hs ? (w_rlast ? R_IDLE : R_FETCH) : R_DATA;
  end
  always_ff @(posedge ACLK or negedge ARESETn)
    if (!ARESETn) begin
      r_rid <= '0; r_raddr <= '0; r_rlen <= '0; r_rcnt <= '0;
      r_rsize <= '0; r_rburst <= '0; r_rerr <= 1'b0;
    end else begin
      if (w_ar_hs) begin
        r_rid    <= ARID;
        r_raddr  <= ARADDR;
        r_rlen   <= ARLEN;
        r_rcnt   <= ARLEN;
        r_rsize  <= ARSIZE;
        r_rburst <= ARBURST;
        r_rerr   <= axi_burst_err(addr_t'(ARADDR), ARSIZE, ARLEN, ARBURST, LB, MEMORY_DEPTH);
      end
      if (w_r_hs && !w_rlast) begin
        r_raddr <= ADDR_WIDTH'(axi_next_addr(addr_t'(r_raddr), r_rsize, r_rlen, r_rburst));
        r_rcnt  <= r_rcnt - 8'd1;
      end
    end
endmodule

// File: tb/tb_axi4_burst_slave.sv
// tb_axi4_burst_slave: directed bursts with a queue scoreboard checked by a separate monitor.
module tb_axi4_burst_slave;
  import axi4_pkg::*;
  localparam int DW = 32, AW = 16, IW = 4;
  logic ACLK = 1'b0, ARESETn = 1'b0;
  logic [IW-1:0] AWID, BID, ARID, RID;
  logic [AW-1:0] AWADDR, ARADDR;
  logic [7:0] AWLEN, ARLEN;
  logic [2:0] AWSIZE, ARSIZE;
  logic [1:0] AWBURST, ARBURST, BRESP, RRESP;
  logic AWVALID, AWREADY, WLAST, WVALID, WREADY, BVALID, BREADY;
  logic ARVALID, ARREADY, RLAST, RVALID, RREADY;
  logic [DW-1:0] WDATA, RDATA;
  logic [DW/8-1:0] WSTRB;
  typedef struct packed {logic [IW-1:0] id; logic [DW-1:0] data; logic [1:0] resp; logic last;} rexp_t;
  typedef struct packed {logic [IW-1:0] id; logic [1:0] resp;} bexp_t;
  rexp_t rq[$];
  bexp_t bq[$];
  rexp_t re;
  bexp_t be;
  int total = 0, bad = 0;
  always #5 ACLK = ~ACLK;
  axi4_burst_slave #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW), .MEMORY_DEPTH(1024)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
    .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
  );
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask
  always @(negedge ACLK) if (ARESETn) begin
    if (BVALID && BREADY) begin
      if (bq.size() == 0) begin
        total++; bad++;
        $display("FAIL b_unexpected: got bid %0h with nothing expected", BID);
      end else begin
        be = bq.pop_front();
        chk("bid", 64'(BID), 64'(be.id));
        chk("bresp", 64'(BRESP), 64'(be.resp));
      end
    end
    if (RVALID && RREADY) begin
      if (rq.size() == 0) begin
        total++; bad++;
        $display("FAIL r_unexpected: got rdata %0h with nothing expected", RDATA);
      end else begin
        re = rq.pop_front();
        chk("rid", 64'(RID), 64'(re.id));
        chk("rdata", 64'(RDATA), 64'(re.data));
        chk("rresp", 64'(RRESP), 64'(re.resp));
        chk("rlast", 64'(RLAST), 64'(re.last));
      end
    end
  end
  function automatic logic sig(input int w);
    return w == 0 ? AWREADY : w == 1 ? WREADY : w == 2 ? ARREADY : w == 3 ? RVALID : BVALID;
  endfunction
  task automatic wait_hi(input int w, input string nm);
    int n = 0;
    @(negedge ACLK);
    while (!sig(w) && n < 100) begin
      @(negedge ACLK);
      n++;
    end
    if (n >= 100) begin
      total++; bad++;
      $display("FAIL %s: timeout got 0 want 1", nm);
    end
  endtask
  task automatic wr(input logic [IW-1:0] id, input logic [AW-1:0] a, input logic [7:0] len,
                    input logic [1:0] burst, input logic [DW-1:0] d0, d1, d2, d3,
                    input logic [3:0] strb, input logic [3:0] wl, input logic [1:0] resp);
    logic [DW-1:0] d[4];
    d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
    bq.push_back({id, resp});
    AWID = id; AWADDR = a; AWLEN = len; AWSIZE = 3'd2; AWBURST = burst; AWVALID = 1'b1;
    wait_hi(0, "awready");
    @(posedge ACLK); #1 AWVALID = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      WDATA = d[i]; WSTRB = strb; WLAST = wl[i]; WVALID = 1'b1;
      wait_hi(1, "wready");
      @(posedge ACLK); #1;
    end
    WVALID = 1'b0; WLAST = 1'b0;
  endtask
  task automatic rd(input logic [IW-1:0] id, input logic [AW-1:0] a, input logic [7:0] len,
                    input logic [1:0] burst, input logic [DW-1:0] d0, d1, d2, d3,
                    input logic [1:0] resp);
    logic [DW-1:0] d[4];
    d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
    for (int i = 0; i <= int'(len); i++) rq.push_back({id, d[i], resp, 1'(i == int'(len))});
    ARID = id; ARADDR = a; ARLEN = len; ARSIZE = 3'd2; ARBURST = burst; ARVALID = 1'b1;
    wait_hi(2, "arready");
    @(posedge ACLK); #1 ARVALID = 1'b0;
  endtask
  task automatic drain();
    int n = 0;
    while ((bq.size() > 0 || rq.size() > 0) && n < 200) begin
      @(negedge ACLK);
      n++;
    end
    total++;
    if (n >= 200) begin
      bad++;
      $display("FAIL drain: timeout with %0d b and %0d r pending, want 0", bq.size(), rq.size());
    end
    @(posedge ACLK); #1;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    AWID = '0; AWADDR = '0; AWLEN = '0; AWSIZE = '0; AWBURST = '0; AWVALID = 1'b0;
    WDATA = '0; WSTRB = '0; WLAST = 1'b0; WVALID = 1'b0; BREADY = 1'b1;
    ARID = '0; ARADDR = '0; ARLEN = '0; ARSIZE = '0; ARBURST = '0; ARVALID = 1'b0; RREADY = 1'b1;
    repeat (3) @(negedge ACLK);
    chk("rst_awready", 64'(AWREADY), 64'd1);
    chk("rst_arready", 64'(ARREADY), 64'd1);
    chk("rst_wready", 64'(WREADY), 64'd0);
    chk("rst_bvalid", 64'(BVALID), 64'd0);
    chk("rst_rvalid", 64'(RVALID), 64'd0);
    chk("rst_rlast", 64'(RLAST), 64'd0);
    chk("rst_bresp", 64'(BRESP), 64'd0);
    chk("rst_rresp", 64'(RRESP), 64'd0);
    chk("rst_rdata", 64'(RDATA), 64'd0);
    chk("rst_bid", 64'(BID), 64'd0);
    chk("rst_rid", 64'(RID), 64'd0);
    @(posedge ACLK); #1 ARESETn = 1'b1;
    wr(5, 16'h0010, 3, BURST_INCR, 32'hA0, 32'hA1, 32'hA2, 32'hA3, 4'hF, 4'b1000, RESP_OKAY);
    drain();
    rd(5, 16'h0010, 3, BURST_INCR, 32'hA0, 32'hA1, 32'hA2, 32'hA3, RESP_OKAY);
    drain();
    wr(1, 16'h0030, 3, BURST_INCR, 32'd0, 32'd1, 32'd2, 32'd3, 4'hF, 4'b1000, RESP_OKAY);
    drain();
    rd(2, 16'h0038, 3, BURST_WRAP, 32'd2, 32'd3, 32'd0, 32'd1, RESP_OKAY);
    drain();
    wr(3, 16'h0004, 2, BURST_FIXED, 32'd1, 32'd2, 32'd3, 32'd0, 4'hF, 4'b0100, RESP_OKAY);
    drain();
    rd(3, 16'h0004, 0, BURST_INCR, 32'd3, 32'd0, 32'd0, 32'd0, RESP_OKAY);
    drain();
    wr(4, 16'h0040, 0, BURST_INCR, 32'hFFFFFFFF, 0, 0, 0, 4'hF, 4'b0001, RESP_OKAY);
    drain();
    wr(4, 16'h0040, 0, BURST_INCR, 32'h11223344, 0, 0, 0, 4'b0101, 4'b0001, RESP_OKAY);
    drain();
    rd(4, 16'h0040, 0, BURST_INCR, 32'hFF22FF44, 0, 0, 0, RESP_OKAY);
    drain();
    wr(8, 16'h0FF8, 1, BURST_INCR, 32'hCAFE0001, 32'hCAFE0002, 0, 0, 4'hF, 4'b0010, RESP_OKAY);
    drain();
    wr(9, 16'h0FF8, 3, BURST_INCR, 32'h1, 32'h2, 32'h3, 32'h4, 4'hF, 4'b1000, RESP_SLVERR);
    drain();
    rd(9, 16'h0FF8, 1, BURST_INCR, 32'hCAFE0001, 32'hCAFE0002, 0, 0, RESP_OKAY);
    drain();
    rd(10, 16'h1000, 0, BURST_INCR, 32'd0, 0, 0, 0, RESP_SLVERR);
    drain();
    rd(11, 16'h0030, 2, BURST_WRAP, 32'd0, 32'd0, 32'd0, 0, RESP_SLVERR);
    drain();
    RREADY = 1'b0;
    rd(7, 16'h001C, 0, BURST_INCR, 32'hA3, 0, 0, 0, RESP_OKAY);
    wait_hi(3, "rvalid_hold");
    for (int i = 0; i < 5; i++) begin
      chk("hold_rvalid", 64'(RVALID), 64'd1);
      chk("hold_rdata", 64'(RDATA), 64'hA3);
      chk("hold_rlast", 64'(RLAST), 64'd1);
      @(negedge ACLK);
    end
    @(posedge ACLK); #1 RREADY = 1'b1;
    drain();
    BREADY = 1'b0;
    wr(12, 16'h0050, 0, BURST_INCR, 32'h55, 0, 0, 0, 4'hF, 4'b0001, RESP_OKAY);
    wait_hi(4, "bvalid_hold");
    for (int i = 0; i < 5; i++) begin
      chk("hold_bvalid", 64'(BVALID), 64'd1);
      chk("hold_bid", 64'(BID), 64'd12);
      @(negedge ACLK);
    end
    @(posedge ACLK); #1 BREADY = 1'b1;
    drain();
    wr(6, 16'h0060, 3, BURST_INCR, 32'h1, 32'h2, 32'h3, 32'h4, 4'hF, 4'b1010, RESP_SLVERR);
    drain();
    wr(13, 16'h0070, 0, BURST_INCR, 32'h7, 0, 0, 0, 4'hF, 4'b0000, RESP_SLVERR);
    drain();
    RREADY = 1'b0;
    rd(14, 16'h0030, 3, BURST_INCR, 32'd0, 32'd1, 32'd2, 32'd3, RESP_OKAY);
    wait_hi(3, "rvalid_pre_reset");
    @(posedge ACLK); #1 ARESETn = 1'b0;
    #1;
    chk("mid_rst_rvalid", 64'(RVALID), 64'd0);
    chk("mid_rst_arready", 64'(ARREADY), 64'd1);
    chk("mid_rst_awready", 64'(AWREADY), 64'd1);
    rq.delete();
    @(posedge ACLK); #1 ARESETn = 1'b1;
    RREADY = 1'b1;
    @(negedge ACLK);
    chk("post_rst_rvalid", 64'(RVALID), 64'd0);
    chk("post_rst_arready", 64'(ARREADY), 64'd1);
    @(posedge ACLK); #1;
    rd(15, 16'h0010, 0, BURST_INCR, 32'hA0, 0, 0, 0, RESP_OKAY);
    drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
